// File: rtl/alu29x03_pkg.sv
// Shared constants for the alu29x03 4-bit ALU slice.
package alu29x03_pkg;
    localparam int W      = 4;
    localparam int CTRL_W = 13;

    // ctrl bit positions
    localparam int APOL = 0;
    localparam int BPOL = 1;
    localparam int AEN  = 2;
    localparam int BEN  = 3;
    localparam int J    = 4;
    localparam int K    = 5;
    localparam int M    = 6;
    localparam int BCD  = 7;

    localparam logic [W-1:0] BCD_MAX = 4'd9;
    localparam logic [W-1:0] BCD_ADJ = 4'd6;

    // Decimal carry: binary carry-out or a nibble beyond 9.
    function automatic logic dec_carry(input logic [W:0] s);
        return s[W] | (s[W-1:0] > BCD_MAX);
    endfunction
endpackage

// File: rtl/alu29x03_if.sv
// Operand/control/result bundle of the ALU slice.
interface alu29x03_if;
    import alu29x03_pkg::*;
    logic [W-1:0]      a;
    logic [W-1:0]      b;
    logic [CTRL_W-1:0] ctrl;
    logic              cn;
    logic [W-1:0]      f;
    logic              gg;
    logic              gp;
    logic              n;
    logic              ovr;
    logic              cn4;
    logic              bcdc4;
    logic [3:0]        stat;

    modport master (output a, b, ctrl, cn,
                    input  f, gg, gp, n, ovr, cn4, bcdc4, stat);
    modport slave  (input  a, b, ctrl, cn,
                    output f, gg, gp, n, ovr, cn4, bcdc4, stat);
endinterface

// File: rtl/alu29x03_cla4.sv
// 4-bit carry-lookahead: internal carries plus active-low group G/P.
module cla4 (
    input  logic [3:0] g,
    input  logic [3:0] p,
    input  logic       cin,
    output logic [4:1] c,
    output logic       gg,
    output logic       gp
);
    // Flat lookahead equations; P is the OR form, which is valid for carries.
    always_comb begin
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (&p & cin);
        gg   = ~(g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]));
        gp   = ~(&p);
    end
endmodule

// File: rtl/alu29x03.sv
// 4-bit ALU slice: logic/arithmetic/decimal modes with a registered status nibble.
module alu29x03
    import alu29x03_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    alu29x03_if.slave bus
);
    logic [W-1:0] ao, bo, g, p, lres, sadj, fr;
    logic [4:1]   c;
    logic [W:0]   s;
    logic         k, bcdc, gg_c, gp_c, z;
    logic         unused_rsvd;

    assign unused_rsvd = ^bus.ctrl[CTRL_W-1:BCD+1];
    assign k           = bus.ctrl[K];

    // Operand gating uses a mux so an undriven disabled operand cannot reach f.
    always_comb begin
        ao = bus.ctrl[AEN] ? (bus.a ^ {W{bus.ctrl[APOL]}}) : '0;
        bo = bus.ctrl[BEN] ? (bus.b ^ {W{bus.ctrl[BPOL]}}) : '0;
        g  = ao & bo;
        p  = ao | bo;
    end

    cla4 u_cla (
        .g   (g),
        .p   (p),
        .cin (bus.cn),
        .c   (c),
        .gg  (gg_c),
        .gp  (gp_c)
    );

    // Sum, decimal correction and mode select ahead of the final inversion.
    always_comb begin
        s    = {c[4], ao ^ bo ^ {c[3:1], bus.cn}};
        bcdc = k & dec_carry(s);
        sadj = (bus.ctrl[BCD] && bcdc) ? (s[W-1:0] + BCD_ADJ) : s[W-1:0];
        lres = bus.ctrl[J] ? ~(ao & bo) : (ao ^ bo);
        fr   = (k ? sadj : lres) ^ {W{bus.ctrl[M]}};
        z    = (fr == '0);
    end

    assign bus.f     = fr;
    assign bus.n     = fr[W-1];
    assign bus.cn4   = k & c[4];
    assign bus.ovr   = k & (c[3] ^ c[4]);
    assign bus.gg    = k ? gg_c : 1'b1;
    assign bus.gp    = k ? gp_c : 1'b1;
    assign bus.bcdc4 = bcdc;

    // Status register {n, ovr, cn4, z}, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) bus.stat <= '0;
        else     bus.stat <= {fr[W-1], k & (c[3] ^ c[4]), k & c[4], z};
    end
endmodule

// File: tb/tb_alu29x03.sv
// Directed bench for alu29x03: stimulus pushes expectations, a monitor pops and compares.
module tb_alu29x03;
    logic clk;
    logic rst;
    alu29x03_if bus();

    alu29x03 dut (.clk(clk), .rst(rst), .bus(bus.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        bit         is_stat;
        logic [9:0] val;   // comb: {f, gg, gp, n, ovr, cn4, bcdc4}; stat: {6'b0, stat}
    } exp_t;

    exp_t q[$];
    event obs_ev;
    int   checks = 0;
    int   errors = 0;

    // Monitor: every observation strobe drains the expectation queue.
    initial begin
        exp_t e;
        logic [9:0] got;
        forever begin
            @(obs_ev);
            while (q.size() > 0) begin
                e = q.pop_front();
                if (e.is_stat) got = {6'b0, bus.stat};
                else got = {bus.f, bus.gg, bus.gp, bus.n, bus.ovr, bus.cn4, bus.bcdc4};
                checks++;
                if (got !== e.val) begin
                    errors++;
                    $display("FAIL %s got %b expected %b", e.name, got, e.val);
                end
            end
        end
    end

    task automatic vec(input string nm, input logic [12:0] c, input logic [3:0] av,
                       input logic [3:0] bv, input logic ci, input logic [9:0] ev);
        bus.a    = av;
        bus.b    = bv;
        bus.ctrl = c;
        bus.cn   = ci;
        #1;
        q.push_back('{nm, 1'b0, ev});
        ->obs_ev;
        #1;
    endtask

    task automatic stat_chk(input string nm, input logic [3:0] ev);
        q.push_back('{nm, 1'b1, {6'b0, ev}});
        ->obs_ev;
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        bus.a    = '0;
        bus.b    = '0;
        bus.ctrl = '0;
        bus.cn   = 1'b0;
        #3;
        stat_chk("reset_stat", 4'b0000);
        @(posedge clk); #1;
        stat_chk("reset_hold", 4'b0000);
        // combinational path ignores rst
        vec("xor_in_rst", 13'h00C, 4'b1100, 4'b1010, 1'b0, 10'b0110_11_0000);
        @(negedge clk);
        rst = 1'b0;

        //                 ctrl     a        b        cn    {f, gg gp, n ovr cn4 bcdc4}
        vec("xor",        13'h00C, 4'b1100, 4'b1010, 1'b0, 10'b0110_11_0000);
        vec("nand_na_b",  13'h01D, 4'b1100, 4'b1010, 1'b0, 10'b1101_11_1000);
        vec("and",        13'h05C, 4'b1100, 4'b1010, 1'b0, 10'b1000_11_1000);
        vec("nand_na_nb", 13'h01F, 4'b1100, 4'b1010, 1'b0, 10'b1110_11_1000);
        vec("const0",     13'h000, 4'bxxxx, 4'bxxxx, 1'b0, 10'b0000_11_0000);
        vec("const1",     13'h040, 4'bxxxx, 4'bxxxx, 1'b1, 10'b1111_11_1000);
        vec("rsvd_ign",   13'h1F0C,4'b1100, 4'b1010, 1'b0, 10'b0110_11_0000);
        vec("add_cn0",    13'h02C, 4'b0101, 4'b0100, 1'b0, 10'b1001_11_1100);
        vec("add_cn1",    13'h02C, 4'b0101, 4'b0100, 1'b1, 10'b1010_11_1101);
        vec("sub",        13'h02E, 4'b0101, 4'b0100, 1'b1, 10'b0001_00_0011);
        vec("negate_b",   13'h02A, 4'b0000, 4'b0101, 1'b1, 10'b1011_11_1001);
        vec("wrap_gg",    13'h02C, 4'b1111, 4'b0001, 1'b0, 10'b0000_00_0011);
        vec("bcd",        13'h0AC, 4'b0111, 4'b0101, 1'b0, 10'b0010_11_0101);
        vec("bcd_inv",    13'h0EC, 4'b0111, 4'b0101, 1'b0, 10'b1101_11_1101);

        // status register tracking
        vec("add_cn0_s",  13'h02C, 4'b0101, 4'b0100, 1'b0, 10'b1001_11_1100);
        @(posedge clk); #1;
        stat_chk("stat_add", 4'b1100);
        vec("sub_s",      13'h02E, 4'b0101, 4'b0100, 1'b1, 10'b0001_00_0011);
        @(posedge clk); #1;
        stat_chk("stat_sub", 4'b0010);
        #1;
        rst = 1'b1;
        #1;
        stat_chk("stat_async_rst", 4'b0000);
        vec("const0_s",   13'h000, 4'b0000, 4'b0000, 1'b0, 10'b0000_11_0000);
        @(negedge clk);
        rst = 1'b0;
        #1;
        stat_chk("stat_after_release", 4'b0000);
        @(posedge clk); #1;
        stat_chk("stat_zero", 4'b0001);

        // bounded drain of anything still pending
        for (int i = 0; i < 10 && q.size() > 0; i++) begin
            ->obs_ev;
            #1;
        end
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
